dbus_uncached_bridge: RTL and testbench
=======================================

Name: dbus_uncached_bridge

Overview:
- Converts one `dbus_req_t` transaction from the CPU memory stage into a single-beat `cbus_req_t` transaction toward the AXI/cbus arbiter.
- Returns the result on `dbus_resp_t`.
- Sits between the memory stage and the cbus arbiter and serves uncached (MMIO) accesses.
- Handles one outstanding request, has a fixed three-state FSM, and includes a response watchdog.

Parameters:
- TIMEOUT, 1024, number of BUSY cycles without a completing beat before `err_timeout` sets; 0 disables the watchdog.
- CNT_W, 16, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- dreq  in  dbus_req_t  request from the CPU; held stable by the CPU until `data_ok`.
- dresp  out  dbus_resp_t  `addr_ok`/`data_ok`/`data` back to the CPU.
- creq  out  cbus_req_t  single-beat request to the cbus arbiter.
- cresp  in  cbus_resp_t  `ready`/`last`/`data` from the cbus arbiter.
- err_timeout  out  1  sticky watchdog flag.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; latched request registers, rdata and the watchdog counter are cleared to 0.
  - err_timeout=0; all dresp fields 0; all creq fields 0.
  - Reset mid-transaction abandons the cbus transfer. The arbiter shares resetn, so no stray beat is accepted afterwards.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On `dreq.valid`, latch addr, size, strobe and data.
  - Set is_write = (strobe != 0).
  - Next state BUSY. No dresp output this cycle.
- BUSY: `creq` is driven purely from the latched registers:
  - creq.valid=1, is_write=latched, size=latched, addr=latched, strobe=latched, data=latched.
  - len=MLEN1, burst=AXI_BURST_INCR.
  - Changes on `dreq` are ignored while in BUSY.
- BUSY completion:
  - `cresp.ready && cresp.last` captures `cresp.data` into rdata (writes capture too; value is don't-care), then next state DONE.
  - `cresp.ready && !cresp.last` is a protocol violation: data is discarded and the FSM stays in BUSY.
- DONE:
  - dresp.addr_ok=1, dresp.data_ok=1, dresp.data=rdata for exactly one cycle; creq.valid=0.
  - Next state IDLE unconditionally. A dreq.valid seen in DONE is not accepted; it is accepted in the following IDLE cycle.
- Outside BUSY, all creq fields are 0. Outside DONE, all dresp fields are 0.
- Latency:
  - dreq.valid first seen in cycle 0 gives creq.valid from cycle 1.
  - A completing beat in cycle k (k≥1) gives data_ok in cycle k+1.
  - Minimum 3 cycles from request to data_ok; back-to-back throughput is 1 request per 3 cycles.
- Data alignment: addr, strobe and data pass through unchanged; the CPU has already placed data and strobe on 8-byte lanes. dresp.data is the full 64-bit bus word.
- Watchdog:
  - The counter clears on entry to BUSY and increments each BUSY cycle, saturating at 2^CNT_W−1.
  - When the counter equals TIMEOUT and TIMEOUT≠0, err_timeout sets.
  - err_timeout is sticky until reset. The FSM keeps waiting and does not abort.
- busy = (state != IDLE).

Test Plan:
- Read: dreq{valid=1, addr=0x1000_0008, size=MSIZE4, strobe=0} at cycle 0; cresp.ready=last=1, data=0xDEAD_BEEF_0000_1234 at cycle 2 → creq.valid cycles 1–2 with is_write=0, len=MLEN1, addr=0x1000_0008; data_ok+addr_ok in cycle 3 with data=0xDEAD_BEEF_0000_1234; creq.valid=0 in cycle 3.
- Write: strobe=8'hF0, data=0x1122_3344_5566_7788, ready at cycle 5 → is_write=1, creq.strobe=8'hF0, creq.data unchanged for cycles 1–5; data_ok in cycle 6 only.
- Stability: change dreq.addr to 0x2000 during BUSY → creq.addr stays 0x1000_0008. ready=1 with last=0 in cycle 2 → no data_ok; ready=last=1 in cycle 4 → data_ok in cycle 5.
- Back-to-back: dreq.valid held high through two requests → second creq.valid rises exactly 3 cycles after the first, i.e. the cycle after the first DONE plus one.
- Watchdog: TIMEOUT=8, never assert ready → err_timeout rises in the 9th BUSY cycle and stays high; late ready=last=1 still produces data_ok. err_timeout clears only on resetn=0.
- Async reset: deassert resetn mid-BUSY, between clock edges → creq.valid, dresp and err_timeout go 0 immediately. After release, a new read completes normally with 3-cycle latency.

Source files
------------

// File: rtl/dbus_uncached_bridge.sv
// Uncached (MMIO) bridge: turns one dbus request into a single-beat cbus
// transfer and returns the result, with a sticky response watchdog.
package dbus_uncached_bridge_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;

  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef logic [3:0] mlen_t;
  localparam mlen_t MLEN1 = 4'd0;

  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    msize_t            size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    mlen_t             len;
    axi_burst_t        burst;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;
endpackage

module dbus_uncached_bridge
  import dbus_uncached_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       err_timeout,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam bit               WDOG_EN     = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  msize_t            size_q, size_d;
  logic [STRB_W-1:0] strobe_q, strobe_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              beat_done;

  assign beat_done = cresp.ready && cresp.last;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state, request latch and watchdog
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (dreq.valid) begin
          state_d    = S_BUSY;
          addr_d     = dreq.addr;
          size_d     = dreq.size;
          strobe_d   = dreq.strobe;
          wdata_d    = dreq.data;
          is_write_d = (dreq.strobe != '0);
          cnt_d      = '0;
        end
      end
      S_BUSY: begin
        // A ready beat without last is a protocol violation and is dropped.
        if (beat_done) begin
          rdata_d = cresp.data;
          state_d = S_DONE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (WDOG_EN && (cnt_d == TIMEOUT_CNT)) err_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    creq        = '0;
    dresp       = '0;
    busy        = (state_q != S_IDLE);
    err_timeout = err_q;
    unique case (state_q)
      S_BUSY: begin
        creq.valid    = 1'b1;
        creq.is_write = is_write_q;
        creq.size     = size_q;
        creq.addr     = addr_q;
        creq.strobe   = strobe_q;
        creq.data     = wdata_q;
        creq.len      = MLEN1;
        creq.burst    = AXI_BURST_INCR;
      end
      S_DONE: begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Bench for dbus_uncached_bridge: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_dbus_uncached_bridge;
  import dbus_uncached_bridge_pkg::*;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 16;

  logic       clk;
  logic       resetn;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       err_timeout;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  dbus_uncached_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .dreq(dreq), .dresp(dresp),
    .creq(creq), .cresp(cresp), .err_timeout(err_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one pending transaction, then a one-cycle response slot
  logic        m_active, m_resp, m_err;
  dbus_req_t   m_req;
  logic [63:0] m_rdata;
  int unsigned m_wait;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_active <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0;
      m_req <= '0; m_rdata <= '0; m_wait <= 0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_active) begin
      if (cresp.ready && cresp.last) begin
        m_rdata  <= cresp.data;
        m_active <= 1'b0;
        m_resp   <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
        if (TIMEOUT != 0 && m_wait + 1 == TIMEOUT) m_err <= 1'b1;
      end
    end else if (dreq.valid) begin
      m_req    <= dreq;
      m_active <= 1'b1;
      m_wait   <= 0;
    end
  end

  function automatic cbus_req_t exp_creq();
    cbus_req_t r;
    r = '0;
    if (m_active) begin
      r.valid    = 1'b1;
      r.is_write = (m_req.strobe != 0);
      r.size     = m_req.size;
      r.addr     = m_req.addr;
      r.strobe   = m_req.strobe;
      r.data     = m_req.data;
      r.len      = MLEN1;
      r.burst    = AXI_BURST_INCR;
    end
    return r;
  endfunction

  function automatic dbus_resp_t exp_dresp();
    dbus_resp_t r;
    r = '0;
    if (m_resp) begin
      r.addr_ok = 1'b1;
      r.data_ok = 1'b1;
      r.data    = m_rdata;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    chk("creq",  192'(creq),  192'(exp_creq()));
    chk("dresp", 192'(dresp), 192'(exp_dresp()));
    chk("busy",  192'(busy),  192'(m_active | m_resp));
    chk("err",   192'(err_timeout), 192'(m_err));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic dbus_req_t mk(input logic [31:0] a, input msize_t s,
                                   input logic [7:0] st, input logic [63:0] d);
    dbus_req_t r;
    r.valid = 1'b1; r.addr = a; r.size = s; r.strobe = st; r.data = d;
    return r;
  endfunction

  function automatic cbus_resp_t beat(input logic lst, input logic [63:0] d);
    cbus_resp_t r;
    r.ready = 1'b1; r.last = lst; r.data = d;
    return r;
  endfunction

  initial begin
    dreq = '0; cresp = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    cycle(); cycle();
    chk("rst_creq_valid", creq.valid, 0);
    chk("rst_dresp", 192'(dresp), 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    resetn = 1'b1;
    cycle();

    // Read: beat in cycle 2, response in cycle 3
    dreq = mk(32'h1000_0008, MSIZE4, 8'h00, 64'h0);
    cycle();
    chk("rd_c1_valid", creq.valid, 1);
    chk("rd_c1_wr", creq.is_write, 0);
    chk("rd_c1_len", creq.len, 0);
    chk("rd_c1_addr", creq.addr, 32'h1000_0008);
    cycle();
    chk("rd_c2_valid", creq.valid, 1);
    cresp = beat(1'b1, 64'hDEAD_BEEF_0000_1234);
    cycle();
    cresp = '0; dreq = '0;
    chk("rd_c3_dok", dresp.data_ok, 1);
    chk("rd_c3_aok", dresp.addr_ok, 1);
    chk("rd_c3_data", dresp.data, 64'hDEAD_BEEF_0000_1234);
    chk("rd_c3_cvalid", creq.valid, 0);
    cycle();
    chk("rd_c4_dok", dresp.data_ok, 0);
    chk("rd_c4_busy", busy, 0);

    // Write: beat in cycle 5, response in cycle 6 only
    dreq = mk(32'h1000_0010, MSIZE8, 8'hF0, 64'h1122_3344_5566_7788);
    for (int c = 1; c <= 5; c++) begin
      cycle();
      chk("wr_iswrite", creq.is_write, 1);
      chk("wr_strobe", creq.strobe, 8'hF0);
      chk("wr_data", creq.data, 64'h1122_3344_5566_7788);
      chk("wr_dok_early", dresp.data_ok, 0);
    end
    cresp = beat(1'b1, 64'h0000_0000_0000_CAFE);
    cycle();
    cresp = '0; dreq = '0;
    chk("wr_c6_dok", dresp.data_ok, 1);
    cycle();
    chk("wr_c7_dok", dresp.data_ok, 0);

    // Stability: addr change ignored, ready without last dropped
    dreq = mk(32'h1000_0008, MSIZE2, 8'h00, 64'h0);
    cycle();
    dreq.addr = 32'h2000;
    cycle();
    cresp = beat(1'b0, 64'h0BAD);
    cycle();
    cresp = '0;
    chk("st_c3_addr", creq.addr, 32'h1000_0008);
    chk("st_c3_dok", dresp.data_ok, 0);
    cycle();
    chk("st_c4_dok", dresp.data_ok, 0);
    cresp = beat(1'b1, 64'h55);
    cycle();
    chk("st_c5_dok", dresp.data_ok, 1);
    chk("st_c5_data", dresp.data, 64'h55);
    cresp = '0; dreq = '0;
    cycle();

    // Back-to-back: valid and ready held high across two requests
    dreq = mk(32'h1000_0020, MSIZE1, 8'h00, 64'h0);
    cresp = beat(1'b1, 64'h1111);
    cycle();
    chk("bb_c1_valid", creq.valid, 1);
    cycle();
    chk("bb_c2_valid", creq.valid, 0);
    chk("bb_c2_dok", dresp.data_ok, 1);
    chk("bb_c2_data", dresp.data, 64'h1111);
    cycle();
    chk("bb_c3_valid", creq.valid, 0);
    cresp = beat(1'b1, 64'h2222);
    cycle();
    chk("bb_c4_valid", creq.valid, 1);
    cycle();
    chk("bb_c5_dok", dresp.data_ok, 1);
    chk("bb_c5_data", dresp.data, 64'h2222);
    dreq = '0; cresp = '0;
    cycle();
    chk("bb_c6_busy", busy, 0);

    // Watchdog: err rises in the 9th BUSY cycle, late beat still completes
    dreq = mk(32'h1000_0030, MSIZE4, 8'h00, 64'h0);
    for (int c = 1; c <= 12; c++) begin
      cycle();
      chk("wd_err", err_timeout, (c >= 9) ? 1 : 0);
    end
    cresp = beat(1'b1, 64'h77);
    cycle();
    chk("wd_c13_dok", dresp.data_ok, 1);
    chk("wd_c13_err", err_timeout, 1);
    cresp = '0; dreq = '0;
    cycle();
    chk("wd_c14_err", err_timeout, 1);
    chk("wd_c14_busy", busy, 0);

    // Async reset mid-BUSY, between clock edges
    dreq = mk(32'h1000_0040, MSIZE4, 8'h00, 64'h0);
    cycle(); cycle();
    #2 resetn = 1'b0;
    #1;
    chk("ar_cvalid", creq.valid, 0);
    chk("ar_dresp", 192'(dresp), 0);
    chk("ar_err", err_timeout, 0);
    chk("ar_busy", busy, 0);
    dreq = '0;
    cycle(); cycle();
    resetn = 1'b1;
    dreq = mk(32'h1000_0048, MSIZE4, 8'h00, 64'h0);
    cycle();
    chk("ar_c1_valid", creq.valid, 1);
    chk("ar_c1_addr", creq.addr, 32'h1000_0048);
    cresp = beat(1'b1, 64'hABCD);
    cycle();
    chk("ar_c2_dok", dresp.data_ok, 1);
    chk("ar_c2_data", dresp.data, 64'hABCD);
    cresp = '0; dreq = '0;
    cycle();
    chk("ar_c3_busy", busy, 0);
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
